// File: rtl/burst_bus_pkg.sv
// Shared definitions for the burst bus: field widths, slave state encoding,
// and the address-decode helpers used by both slaves and initiators.
package burst_bus_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned BE_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        RD_END,
        WR_DATA,
        WR_STALL,
        ERR_END
    } slave_state_t;

    // True when the byte address falls inside the 4*2^addr_bits window at base.
    function automatic logic window_hit(
        input logic [DATA_W-1:0] addr,
        input logic [DATA_W-1:0] base,
        input int unsigned       addr_bits
    );
        logic [DATA_W-1:0] mask;
        mask = '1 << (addr_bits + 2);
        return (addr & mask) == (base & mask);
    endfunction

    // True when the last beat of a burst would fall past the end of the SRAM.
    function automatic logic range_error(
        input logic [DATA_W-1:0]  index,
        input logic [BURST_W-1:0] burst,
        input int unsigned        addr_bits
    );
        logic [DATA_W:0] last_word;
        logic [DATA_W:0] limit;
        last_word = {1'b0, index} + {{(DATA_W-BURST_W+1){1'b0}}, burst};
        limit     = ((DATA_W+1)'(1) << addr_bits) - (DATA_W+1)'(1);
        return last_word > limit;
    endfunction

endpackage

// File: rtl/bus_slave_ram.sv
// Single-port synchronous SRAM, 2^ADDR_BITS x 32, byte write enables,
// one-cycle registered read.
module bus_slave_ram
    import burst_bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [BE_W-1:0]      we,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clock) begin
        for (int unsigned lane = 0; lane < BE_W; lane++) begin
            if (we[lane]) begin
                mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/burst_sram_slave.sv
// Burst bus slave backed by a local SRAM: window decode, read/write bursts,
// optional write stalls and range-error termination. Outputs are 0 when idle.
module burst_sram_slave
    import burst_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h5000_0000,
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WRITE_STALL  = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   addressDataIn,
    input  logic                beginTransactionIn,
    input  logic                endTransactionIn,
    input  logic                dataValidIn,
    input  logic                readNotWriteIn,
    input  logic [BURST_W-1:0]  burstSizeIn,
    input  logic [BE_W-1:0]     byteEnablesIn,
    output logic [DATA_W-1:0]   addressDataOut,
    output logic                dataValidOut,
    output logic                endTransactionOut,
    output logic                busErrorOut,
    output logic                busyOut
);

    slave_state_t         state;
    logic [ADDR_BITS-1:0] base_index;
    logic [BURST_W-1:0]   burst_len;
    logic [BE_W-1:0]      lanes;
    logic [8:0]           beat;
    logic [3:0]           wait_cnt;
    logic                 data_valid;
    logic                 end_tx;
    logic                 bus_err;
    logic                 busy;

    logic                 hit;
    logic                 beat_ok;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [BE_W-1:0]      ram_we;
    logic [DATA_W-1:0]    ram_rdata;

    assign hit     = window_hit(addressDataIn, BASE_ADDR, ADDR_BITS);
    assign beat_ok = (state == WR_DATA) && dataValidIn && (beat <= {1'b0, burst_len});

    // During RD_DATA the RAM is addressed one word ahead so the next beat is
    // ready on the following cycle; RD_WAIT already fetches word 0.
    always_comb begin
        ram_addr = base_index + ADDR_BITS'(beat) + ADDR_BITS'(state == RD_DATA);
        ram_we   = (reset && beat_ok) ? lanes : '0;
    end

    bus_slave_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clock(clock),
        .addr (ram_addr),
        .we   (ram_we),
        .wdata(addressDataIn),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            base_index <= '0;
            burst_len  <= '0;
            lanes      <= '0;
            beat       <= '0;
            wait_cnt   <= '0;
            data_valid <= 1'b0;
            end_tx     <= 1'b0;
            bus_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            end_tx     <= 1'b0;
            bus_err    <= 1'b0;
            busy       <= 1'b0;
            case (state)
                IDLE: begin
                    if (beginTransactionIn && hit) begin
                        base_index <= addressDataIn[ADDR_BITS+1:2];
                        burst_len  <= burstSizeIn;
                        lanes      <= byteEnablesIn;
                        beat       <= '0;
                        if (range_error(DATA_W'(addressDataIn[ADDR_BITS+1:2]),
                                        burstSizeIn, ADDR_BITS)) begin
                            state   <= ERR_END;
                            bus_err <= 1'b1;
                            end_tx  <= 1'b1;
                        end else if (readNotWriteIn) begin
                            state    <= RD_WAIT;
                            wait_cnt <= 4'(READ_LATENCY - 1);
                        end else begin
                            state <= WR_DATA;
                        end
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        state      <= RD_DATA;
                        data_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RD_DATA: begin
                    if (beat == {1'b0, burst_len}) begin
                        state  <= RD_END;
                        end_tx <= 1'b1;
                    end else begin
                        beat       <= beat + 9'd1;
                        data_valid <= 1'b1;
                    end
                end
                RD_END: state <= IDLE;
                WR_DATA: begin
                    if (beat_ok) begin
                        beat <= beat + 9'd1;
                    end
                    if (endTransactionIn) begin
                        state <= IDLE;
                    end else if (beat_ok && (WRITE_STALL != 0)) begin
                        state <= WR_STALL;
                        busy  <= 1'b1;
                    end
                end
                WR_STALL: state <= endTransactionIn ? IDLE : WR_DATA;
                ERR_END:  state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign addressDataOut    = data_valid ? ram_rdata : '0;
    assign dataValidOut      = data_valid;
    assign endTransactionOut = end_tx;
    assign busErrorOut       = bus_err;
    assign busyOut           = busy;

endmodule

// File: tb/tb_burst_sram_slave.sv
// Directed bench: slave A (0x5000_0000, no stalls) and slave B (0x6000_0000,
// write stalls) share the bus inputs; each scenario checks its own slave.
module tb_burst_sram_slave;

    localparam logic [31:0] BASE_A = 32'h5000_0000;
    localparam logic [31:0] BASE_B = 32'h6000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] addr_data;
    logic        beg_in;
    logic        end_in;
    logic        dv_in;
    logic        rnw_in;
    logic [7:0]  burst_in;
    logic [3:0]  be_in;

    logic [31:0] a_data, b_data;
    logic        a_dv, a_end, a_err, a_busy;
    logic        b_dv, b_end, b_err, b_busy;

    int unsigned vectors;
    int unsigned miscompares;

    logic [31:0] obs_data [1:24];
    logic        obs_dv   [1:24];
    logic        obs_end  [1:24];
    logic        obs_err  [1:24];
    logic        obs_busy [1:24];

    burst_sram_slave #(
        .BASE_ADDR   (BASE_A),
        .ADDR_BITS   (10),
        .READ_LATENCY(2),
        .WRITE_STALL (0)
    ) u_slave_a (
        .clock             (clock),
        .reset             (reset),
        .addressDataIn     (addr_data),
        .beginTransactionIn(beg_in),
        .endTransactionIn  (end_in),
        .dataValidIn       (dv_in),
        .readNotWriteIn    (rnw_in),
        .burstSizeIn       (burst_in),
        .byteEnablesIn     (be_in),
        .addressDataOut    (a_data),
        .dataValidOut      (a_dv),
        .endTransactionOut (a_end),
        .busErrorOut       (a_err),
        .busyOut           (a_busy)
    );

    burst_sram_slave #(
        .BASE_ADDR   (BASE_B),
        .ADDR_BITS   (10),
        .READ_LATENCY(2),
        .WRITE_STALL (1)
    ) u_slave_b (
        .clock             (clock),
        .reset             (reset),
        .addressDataIn     (addr_data),
        .beginTransactionIn(beg_in),
        .endTransactionIn  (end_in),
        .dataValidIn       (dv_in),
        .readNotWriteIn    (rnw_in),
        .burstSizeIn       (burst_in),
        .byteEnablesIn     (be_in),
        .addressDataOut    (b_data),
        .dataValidOut      (b_dv),
        .endTransactionOut (b_end),
        .busErrorOut       (b_err),
        .busyOut           (b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change just after a falling edge; outputs are read there too.
    task automatic start_burst(input logic [31:0] addr, input logic rnw,
                               input logic [7:0] burst, input logic [3:0] be);
        beg_in    = 1'b1;
        addr_data = addr;
        rnw_in    = rnw;
        burst_in  = burst;
        be_in     = be;
        dv_in     = 1'b0;
        end_in    = 1'b0;
        @(negedge clock);
        beg_in    = 1'b0;
        addr_data = '0;
    endtask

    task automatic present(input logic dv, input logic [31:0] data, input logic endt);
        dv_in     = dv;
        addr_data = data;
        end_in    = endt;
        @(negedge clock);
    endtask

    // Records n cycles of one slave's outputs; optionally injects a write begin.
    task automatic capture(input logic sel, input int unsigned n, input int unsigned inj);
        for (int unsigned c = 1; c <= n; c++) begin
            obs_data[c] = sel ? b_data : a_data;
            obs_dv[c]   = sel ? b_dv   : a_dv;
            obs_end[c]  = sel ? b_end  : a_end;
            obs_err[c]  = sel ? b_err  : a_err;
            obs_busy[c] = sel ? b_busy : a_busy;
            if (c == inj) begin
                beg_in    = 1'b1;
                rnw_in    = 1'b0;
                burst_in  = 8'd0;
                addr_data = BASE_A + 32'h20;
                dv_in     = 1'b1;
            end else begin
                beg_in    = 1'b0;
                addr_data = '0;
                dv_in     = 1'b0;
            end
            @(negedge clock);
        end
        beg_in = 1'b0;
        dv_in  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        beg_in    = 1'b1;
        rnw_in    = 1'b1;
        addr_data = BASE_A + 32'h10;
        @(negedge clock);
        @(negedge clock);
        beg_in    = 1'b0;
        addr_data = '0;
        vectors++;
        if ({a_data, a_dv, a_end, a_err, a_busy} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_a: got data=%h dv=%b end=%b err=%b busy=%b, expected all 0",
                     a_data, a_dv, a_end, a_err, a_busy);
        end
        vectors++;
        if ({b_data, b_dv, b_end, b_err, b_busy} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_b: got data=%h dv=%b end=%b err=%b busy=%b, expected all 0",
                     b_data, b_dv, b_end, b_err, b_busy);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_write_burst();
        start_burst(BASE_A + 32'h10, 1'b0, 8'd3, 4'hF);
        for (int unsigned c = 1; c <= 6; c++) begin
            vectors++;
            if ({a_busy, a_end, a_err, a_dv} !== 4'b0000) begin
                miscompares++;
                $display("FAIL write_burst cycle %0d: busy/end/err/dv=%b expected 0000",
                         c, {a_busy, a_end, a_err, a_dv});
            end
            if (c <= 4)      present(1'b1, 32'h1111_1111 * c, 1'b0);
            else if (c == 5) present(1'b0, '0, 1'b1);
            else             present(1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_read_back();
        logic [35:0] got, want;
        start_burst(BASE_A + 32'h10, 1'b1, 8'd3, 4'hF);
        capture(1'b0, 8, 0);
        for (int unsigned c = 1; c <= 8; c++) begin
            want = {(c >= 3 && c <= 6), (c == 7), 1'b0, 1'b0,
                    (c >= 3 && c <= 6) ? 32'h1111_1111 * (c - 2) : 32'h0};
            got  = {obs_dv[c], obs_end[c], obs_err[c], obs_busy[c], obs_data[c]};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL read_back cycle %0d: dv/end/err/busy/data got %h expected %h",
                         c, got, want);
            end
        end
    endtask

    task automatic test_stall_write();
        logic [35:0] got, want;
        // Zero words 8..10 of slave B: beats accepted on odd cycles, stalls between.
        start_burst(BASE_B + 32'h20, 1'b0, 8'd2, 4'hF);
        for (int unsigned c = 1; c <= 7; c++) begin
            vectors++;
            if (b_busy !== ((c % 2) == 0)) begin
                miscompares++;
                $display("FAIL stall_zero busy cycle %0d: got %b expected %b", c, b_busy, (c % 2) == 0);
            end
            if (c <= 6) present(1'b1, 32'h0, 1'b0);
            else        present(1'b0, 32'h0, 1'b1);
        end
        present(1'b0, '0, 1'b0);

        // Partial write of two beats; the extra beat after the burst is discarded.
        start_burst(BASE_B + 32'h20, 1'b0, 8'd1, 4'b0011);
        for (int unsigned c = 1; c <= 7; c++) begin
            vectors++;
            if (b_busy !== (c == 2 || c == 4)) begin
                miscompares++;
                $display("FAIL stall_partial busy cycle %0d: got %b expected %b",
                         c, b_busy, (c == 2 || c == 4));
            end
            if (c <= 3)      present(1'b1, 32'hAABB_CCDD, 1'b0);
            else if (c <= 6) present(1'b1, 32'h1234_5678, 1'b0);
            else             present(1'b0, '0, 1'b1);
        end
        present(1'b0, '0, 1'b0);

        start_burst(BASE_B + 32'h20, 1'b1, 8'd2, 4'hF);
        capture(1'b1, 7, 0);
        for (int unsigned c = 1; c <= 7; c++) begin
            want = {(c >= 3 && c <= 5), (c == 6), 1'b0, 1'b0,
                    (c == 3 || c == 4) ? 32'h0000_CCDD : 32'h0};
            got  = {obs_dv[c], obs_end[c], obs_err[c], obs_busy[c], obs_data[c]};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL stall_readback cycle %0d: dv/end/err/busy/data got %h expected %h",
                         c, got, want);
            end
        end
    endtask

    task automatic test_range_error();
        logic [35:0] got, want;
        // Last word with burstSize 0 is legal.
        start_burst(BASE_A + 32'hFFC, 1'b0, 8'd0, 4'hF);
        for (int unsigned c = 1; c <= 2; c++) begin
            vectors++;
            if ({a_err, a_end} !== 2'b00) begin
                miscompares++;
                $display("FAIL range_legal cycle %0d: err/end=%b expected 00", c, {a_err, a_end});
            end
            if (c == 1) present(1'b1, 32'h0BAD_F00D, 1'b0);
            else        present(1'b0, '0, 1'b1);
        end
        present(1'b0, '0, 1'b0);

        start_burst(BASE_A + 32'hFFC, 1'b0, 8'd1, 4'hF);
        vectors++;
        if ({a_err, a_end, a_dv, a_busy, a_data} !== {4'b1100, 32'h0}) begin
            miscompares++;
            $display("FAIL range_write_err: err/end/dv/busy=%b data=%h expected 1100 / 0",
                     {a_err, a_end, a_dv, a_busy}, a_data);
        end
        present(1'b1, 32'hDEAD_BEEF, 1'b0);
        vectors++;
        if ({a_err, a_end, a_dv, a_busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL range_write_after: err/end/dv/busy=%b expected 0000", {a_err, a_end, a_dv, a_busy});
        end
        present(1'b1, 32'hDEAD_BEEF, 1'b0);
        present(1'b0, '0, 1'b0);

        start_burst(BASE_A + 32'hFFC, 1'b1, 8'd1, 4'hF);
        capture(1'b0, 3, 0);
        for (int unsigned c = 1; c <= 3; c++) begin
            want = {1'b0, (c == 1), (c == 1), 1'b0, 32'h0};
            got  = {obs_dv[c], obs_end[c], obs_err[c], obs_busy[c], obs_data[c]};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL range_read_err cycle %0d: got %h expected %h", c, got, want);
            end
        end

        start_burst(BASE_A + 32'hFFC, 1'b1, 8'd0, 4'hF);
        capture(1'b0, 5, 0);
        for (int unsigned c = 1; c <= 5; c++) begin
            want = {(c == 3), (c == 4), 1'b0, 1'b0, (c == 3) ? 32'h0BAD_F00D : 32'h0};
            got  = {obs_dv[c], obs_end[c], obs_err[c], obs_busy[c], obs_data[c]};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL range_followup_read cycle %0d: got %h expected %h", c, got, want);
            end
        end
    endtask

    task automatic test_miss_and_busy_begin();
        logic [35:0] got, want;
        start_burst(BASE_A + 32'h1000, 1'b1, 8'd0, 4'hF);
        capture(1'b0, 5, 0);
        for (int unsigned c = 1; c <= 5; c++) begin
            got = {obs_dv[c], obs_end[c], obs_err[c], obs_busy[c], obs_data[c]};
            vectors++;
            if (got !== 36'h0) begin
                miscompares++;
                $display("FAIL window_miss cycle %0d: got %h expected 0", c, got);
            end
        end

        start_burst(BASE_A + 32'h10, 1'b1, 8'd3, 4'hF);
        capture(1'b0, 8, 4);
        for (int unsigned c = 1; c <= 8; c++) begin
            want = {(c >= 3 && c <= 6), (c == 7), 1'b0, 1'b0,
                    (c >= 3 && c <= 6) ? 32'h1111_1111 * (c - 2) : 32'h0};
            got  = {obs_dv[c], obs_end[c], obs_err[c], obs_busy[c], obs_data[c]};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL busy_begin cycle %0d: got %h expected %h", c, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [35:0] got, want;
        start_burst(BASE_A + 32'h10, 1'b1, 8'd3, 4'hF);
        for (int unsigned c = 1; c <= 9; c++) begin
            want = {(c == 3 || c == 4), 1'b0, 1'b0, 1'b0,
                    (c == 3 || c == 4) ? 32'h1111_1111 * (c - 2) : 32'h0};
            got  = {a_dv, a_end, a_err, a_busy, a_data};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid_read cycle %0d: got %h expected %h", c, got, want);
            end
            if (c == 4) reset = 1'b0;
            if (c == 5) reset = 1'b1;
            @(negedge clock);
        end

        start_burst(BASE_A + 32'h10, 1'b1, 8'd0, 4'hF);
        capture(1'b0, 5, 0);
        for (int unsigned c = 1; c <= 5; c++) begin
            want = {(c == 3), (c == 4), 1'b0, 1'b0, (c == 3) ? 32'h1111_1111 : 32'h0};
            got  = {obs_dv[c], obs_end[c], obs_err[c], obs_busy[c], obs_data[c]};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL read_after_reset cycle %0d: got %h expected %h", c, got, want);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        addr_data   = '0;
        beg_in      = 1'b0;
        end_in      = 1'b0;
        dv_in       = 1'b0;
        rnw_in      = 1'b0;
        burst_in    = '0;
        be_in       = '0;
        @(negedge clock);

        test_reset();
        test_write_burst();
        test_read_back();
        test_stall_write();
        test_range_error();
        test_miss_and_busy_begin();
        test_reset_mid_read();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
